pipe_decoder: RTL and testbench

PIPE_DECODER -- requirements
Module: pipe_decoder

---
 rtl/pipe_dec_pkg.sv | 16 +
 rtl/onehot_dec.sv | 16 +
 rtl/pipe_decoder.sv | 119 +++++++++++
 tb/tb_pipe_decoder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pipe_dec_pkg.sv
// Shared types and constants for the pipelined one-hot decoder.
//   state_e     : FSM states (idle, single decode, multi-cycle scan)
//   MODE_DECODE : mode value selecting a single registered decode
//   MODE_SCAN   : mode value selecting an OUTS-cycle walking scan
package pipe_dec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StScan
  } state_e;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder.
//   idx : binary index, N bits
//   y   : one-hot code, 2**N bits, bit idx set
module onehot_dec #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]      idx,
  output logic [(2**N)-1:0] y
);

  always_comb begin
    y      = '0;
    y[idx] = 1'b1;
  end

endmodule

// File: rtl/pipe_decoder.sv
// Registered one-hot decoder with a walking-scan mode.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : global enable; low freezes all state and outputs
//   mode      : 0 = single decode, 1 = scan (sampled at acceptance)
//   in_valid  : request present
//   in_sel    : binary select / scan start index
//   in_ready  : request can be accepted this cycle
//   out_valid : out_y holds a valid one-hot code
//   out_y     : registered one-hot output, inverted when ACTIVE_LOW
//   busy      : scan in progress
module pipe_decoder
  import pipe_dec_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [N-1:0]        in_sel,
  output logic                in_ready,
  output logic                out_valid,
  output logic [(2**N)-1:0]   out_y,
  output logic                busy
);

  localparam int unsigned OUTS = 2**N;
  localparam logic [OUTS-1:0] YPol  = {OUTS{ACTIVE_LOW}};
  localparam logic [OUTS-1:0] YIdle = YPol;

  state_e          state_q, state_d;
  logic [N-1:0]    scan_idx_q, scan_idx_d;
  logic [N-1:0]    scan_last_q, scan_last_d;
  logic            out_valid_q, out_valid_d;
  logic [OUTS-1:0] out_y_q, out_y_d;

  logic [N-1:0]    scan_next;
  logic [N-1:0]    dec_idx;
  logic [OUTS-1:0] dec_y;

  // Wraps modulo OUTS for free since OUTS is a power of two.
  assign scan_next = scan_idx_q + N'(1);

  // A single decoder serves both paths: the next scan position while
  // scanning, otherwise the incoming select.
  assign dec_idx = (state_q == StScan) ? scan_next : in_sel;

  onehot_dec #(
    .N(N)
  ) u_onehot_dec (
    .idx(dec_idx),
    .y  (dec_y)
  );

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    scan_last_d = scan_last_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (en) begin
      case (state_q)
        StScan: begin
          if (scan_idx_q == scan_last_q) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_y_d     = YIdle;
          end else begin
            scan_idx_d = scan_next;
            out_y_d    = dec_y ^ YPol;
          end
        end
        default: begin
          // in_ready is high here, so in_valid alone means acceptance.
          if (in_valid) begin
            out_valid_d = 1'b1;
            out_y_d     = dec_y ^ YPol;
            if (mode == MODE_SCAN) begin
              state_d     = StScan;
              scan_idx_d  = in_sel;
              scan_last_d = in_sel - N'(1);
            end else begin
              state_d = StDecode;
            end
          end else begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_y_d     = YIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      scan_idx_q  <= '0;
      scan_last_q <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= YIdle;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      scan_last_q <= scan_last_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  assign in_ready  = en & (state_q != StScan);
  assign busy      = (state_q == StScan);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_pipe_decoder.sv
module tb_pipe_decoder;

  typedef struct {
    logic        en;
    logic        mode;
    logic        vld;
    logic [3:0]  sel;
    logic        exp_vld;
    logic [15:0] exp_y;
    logic        exp_busy;
    logic        exp_rdy;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        en, mode, in_valid;
  logic [3:0]  in_sel;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_y;

  logic        en2, mode2, in_valid2;
  logic [2:0]  in_sel2;
  logic        in_ready2, out_valid2, busy2;
  logic [7:0]  out_y2;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  pipe_decoder #(.N(4), .ACTIVE_LOW(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_y    (out_y),
    .busy     (busy)
  );

  pipe_decoder #(.N(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en2),
    .mode     (mode2),
    .in_valid (in_valid2),
    .in_sel   (in_sel2),
    .in_ready (in_ready2),
    .out_valid(out_valid2),
    .out_y    (out_y2),
    .busy     (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic m, input logic v, input logic [3:0] s,
                              input logic ev, input logic [15:0] ey, input logic eb,
                              input logic er);
    vec_t r;
    r.en = e; r.mode = m; r.vld = v; r.sel = s;
    r.exp_vld = ev; r.exp_y = ey; r.exp_busy = eb; r.exp_rdy = er;
    return r;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    en = v.en; mode = v.mode; in_valid = v.vld; in_sel = v.sel;
    @(posedge clk);
    #1;
    check({tag, ".out_y"},     out_y,            v.exp_y);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, v.exp_vld});
    check({tag, ".busy"},      {15'd0, busy},      {15'd0, v.exp_busy});
    check({tag, ".in_ready"},  {15'd0, in_ready},  {15'd0, v.exp_rdy});
  endtask

  initial begin
    logic [15:0] one;
    one = 16'h0001;

    // Decode sweep, then an idle cycle.
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 1, 4'(i), 1, one << i, 0, 1));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 16'h0000, 0, 1));
    // Scan from 14 with a held, ignored request for sel=2.
    tbl.push_back(mk(1, 1, 1, 4'd14, 1, 16'h4000, 1, 0));
    for (int k = 1; k < 16; k++) tbl.push_back(mk(1, 0, 1, 4'd2, 1, one << ((14 + k) % 16), 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'd2, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(1, 0, 1, 4'd2, 1, 16'h0004, 0, 1));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 16'h0000, 0, 1));

    rst_n = 1'b0;
    en = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = '0;
    en2 = 1'b1; mode2 = 1'b0; in_valid2 = 1'b0; in_sel2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_y",     out_y,             16'h0000);
    check("rst.out_valid", {15'd0, out_valid}, 16'd0);
    check("rst.busy",      {15'd0, busy},      16'd0);
    check("rst.in_ready",  {15'd0, in_ready},  16'd1);
    check("rst.al_out_y",  {8'd0, out_y2},     16'h00FF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Active-low polarity, N=3.
    in_valid2 = 1'b1; in_sel2 = 3'd5;
    @(posedge clk);
    #1;
    check("al.out_y",     {8'd0, out_y2},     16'h00DF);
    check("al.out_valid", {15'd0, out_valid2}, 16'd1);
    in_valid2 = 1'b0;
    @(posedge clk);
    #1;
    check("al.idle_y",     {8'd0, out_y2},     16'h00FF);
    check("al.idle_valid", {15'd0, out_valid2}, 16'd0);

    // Enable stall at scan bit 3, then resume.
    apply(mk(1, 1, 1, 4'd0, 1, 16'h0001, 1, 0), "stall.acc");
    for (int k = 1; k < 4; k++) apply(mk(1, 0, 0, 4'd0, 1, one << k, 1, 0), "stall.run");
    for (int k = 0; k < 5; k++) apply(mk(0, 0, 0, 4'd0, 1, 16'h0008, 1, 0), "stall.hold");
    for (int k = 4; k < 8; k++) apply(mk(1, 0, 0, 4'd0, 1, one << k, 1, 0), "stall.resume");

    // Asynchronous reset at scan bit 7, mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_y",     out_y,              16'h0000);
    check("arst.out_valid", {15'd0, out_valid}, 16'd0);
    check("arst.busy",      {15'd0, busy},      16'd0);
    check("arst.in_ready",  {15'd0, in_ready},  16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 0, 0, 4'd0, 0, 16'h0000, 0, 1), "post_rst");
    apply(mk(1, 0, 1, 4'd9, 1, 16'h0200, 0, 1), "post_rst_dec");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
